// File: rtl/cache_pkg.sv
// Cache geometry shared by the way array and its controller.
// Default configuration; the way array takes these as parameter defaults.
package cache_pkg;

  localparam int ADDRESS_WIDTH   = 32;
  localparam int SETS            = 1024;
  localparam int WAYS            = 2;
  localparam int CACHE_LINE_SIZE = 32;
  localparam int OFFSET_BITS     = $clog2(CACHE_LINE_SIZE / 8);
  localparam int SET_BITS        = $clog2(SETS);
  localparam int TAG_WIDTH       =
    ADDRESS_WIDTH - SET_BITS - OFFSET_BITS;

endpackage

// File: rtl/interface_pkg.sv
// Request/response bundles and FSM state type of the way array.
// Bundles are sized for the default cache geometry.
package interface_pkg;

  import cache_pkg::*;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    FLUSH = 2'd2
  } way_array_state_e;

  typedef struct packed {
    logic                         valid;
    logic [ADDRESS_WIDTH-1:0]     address;
    logic [TAG_WIDTH-1:0]         tag;
    logic [CACHE_LINE_SIZE-1:0]   data;
    logic [CACHE_LINE_SIZE/8-1:0] strobe;
    logic [WAYS-1:0]              wen_data;
    logic [WAYS-1:0]              wen_tag;
    logic [WAYS*2-1:0]            valid_dirty;
  } way_array_req_t;

  typedef struct packed {
    logic                            valid;
    logic [WAYS*CACHE_LINE_SIZE-1:0] data;
    logic [WAYS*TAG_WIDTH-1:0]       tag;
    logic [WAYS*2-1:0]               valid_dirty;
  } way_array_resp_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port RAM: 1-cycle read, per-byte write enable, read-old.
// Ports: clk, rst_n, en (read), we, be, addr, wdata, rdata.
module sram_1rw_be #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       we,
  input  logic [(WIDTH+7)/8-1:0]     be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read port register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (be[b/8]) mem[addr][b] <= wdata[b];
      end
    end
  end

  // Holds its value unless a read is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_way_array.sv
// Per-way tag, valid/dirty and data storage with clearing sweep.
// Ports: req_* handshake in, resp_* per-way line out, flush/init status.
module cache_way_array
  import interface_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = cache_pkg::ADDRESS_WIDTH,
  parameter int SETS            = cache_pkg::SETS,
  parameter int WAYS            = cache_pkg::WAYS,
  parameter int CACHE_LINE_SIZE = cache_pkg::CACHE_LINE_SIZE,
  parameter int TAG_WIDTH       = ADDRESS_WIDTH - $clog2(SETS)
                                  - $clog2(CACHE_LINE_SIZE / 8)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDRESS_WIDTH-1:0]        req_address,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  input  logic [CACHE_LINE_SIZE-1:0]      req_data,
  input  logic [CACHE_LINE_SIZE/8-1:0]    req_strobe,
  input  logic [WAYS-1:0]                 req_wen_data,
  input  logic [WAYS-1:0]                 req_wen_tag,
  input  logic [WAYS*2-1:0]               req_valid_dirty,
  input  logic                            flush_req,
  output logic                            flush_busy,
  output logic                            init_done,
  output logic                            resp_valid,
  output logic [WAYS*CACHE_LINE_SIZE-1:0] resp_data,
  output logic [WAYS*TAG_WIDTH-1:0]       resp_tag,
  output logic [WAYS*2-1:0]               resp_valid_dirty
);

  localparam int SET_BITS    = $clog2(SETS);
  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam int TAG_BYTES   = (TAG_WIDTH + 7) / 8;
  localparam logic [SET_BITS-1:0] CNT_LAST =
    SET_BITS'(SETS - 1);

  way_array_state_e    state;
  logic [SET_BITS-1:0] cnt;
  logic [SET_BITS-1:0] addr;
  logic                sweep;
  logic                accept;
  logic                unused_addr;

  assign req_ready = (state == READY);
  assign sweep     = (state != READY);
  assign accept    = req_valid & req_ready;
  assign addr      = sweep ? cnt
                           : req_address[OFFSET_BITS +: SET_BITS];

  // Offset and tag bits of the address play no part in indexing.
  assign unused_addr = ^req_address;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      flush_busy <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= accept;
      unique case (state)
        INIT, FLUSH: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            state      <= READY;
            init_done  <= 1'b1;
            flush_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (flush_req) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic                 meta_we;
    logic                 data_we;
    logic [1:0]           vd_wdata;
    logic [TAG_WIDTH-1:0] tag_wdata;

    // The sweep owns the metadata ports; data is never cleared.
    assign meta_we   = sweep | (accept & req_wen_tag[w]);
    assign data_we   = accept & req_wen_data[w];
    assign vd_wdata  = sweep ? 2'b00
                             : req_valid_dirty[2*w +: 2];
    assign tag_wdata = sweep ? '0 : req_tag;

    sram_1rw_be #(
      .DEPTH (SETS),
      .WIDTH (2)
    ) u_vd (
      .clk   (clk),
      .rst_n (rst),
      .en    (accept),
      .we    (meta_we),
      .be    (1'b1),
      .addr  (addr),
      .wdata (vd_wdata),
      .rdata (resp_valid_dirty[2*w +: 2])
    );

    sram_1rw_be #(
      .DEPTH (SETS),
      .WIDTH (TAG_WIDTH)
    ) u_tag (
      .clk   (clk),
      .rst_n (rst),
      .en    (accept),
      .we    (meta_we),
      .be    ({TAG_BYTES{1'b1}}),
      .addr  (addr),
      .wdata (tag_wdata),
      .rdata (resp_tag[w*TAG_WIDTH +: TAG_WIDTH])
    );

    sram_1rw_be #(
      .DEPTH (SETS),
      .WIDTH (CACHE_LINE_SIZE)
    ) u_data (
      .clk   (clk),
      .rst_n (rst),
      .en    (accept),
      .we    (data_we),
      .be    (req_strobe),
      .addr  (addr),
      .wdata (req_data),
      .rdata (resp_data[w*CACHE_LINE_SIZE +: CACHE_LINE_SIZE])
    );
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed bench for cache_way_array with a line-level reference model.
// Checks every cycle against the model plus literal expectations.
module tb_cache_way_array;

  localparam int SETS = 16;
  localparam int TW   = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_address = '0;
  logic [TW-1:0] req_tag = '0;
  logic [31:0]   req_data = '0;
  logic [3:0]    req_strobe = '0;
  logic [1:0]    req_wen_data = '0;
  logic [1:0]    req_wen_tag = '0;
  logic [3:0]    req_valid_dirty = '0;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          init_done;
  logic          resp_valid;
  logic [63:0]   resp_data;
  logic [2*TW-1:0] resp_tag;
  logic [3:0]    resp_valid_dirty;

  cache_way_array #(
    .ADDRESS_WIDTH   (32),
    .SETS            (SETS),
    .WAYS            (2),
    .CACHE_LINE_SIZE (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_address      (req_address),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .req_strobe       (req_strobe),
    .req_wen_data     (req_wen_data),
    .req_wen_tag      (req_wen_tag),
    .req_valid_dirty  (req_valid_dirty),
    .flush_req        (flush_req),
    .flush_busy       (flush_busy),
    .init_done        (init_done),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_tag         (resp_tag),
    .resp_valid_dirty (resp_valid_dirty)
  );

  always #5 clk = ~clk;

  // Reference model: line contents, busy countdown, held response.
  logic [31:0]   mdata  [2][SETS];
  logic [3:0]    mknown [2][SETS];
  logic [TW-1:0] mtag   [2][SETS];
  logic [1:0]    mvd    [2][SETS];
  int            left   = SETS;
  logic          m_init = 1'b0;
  logic          m_busy = 1'b0;
  logic          e_rv   = 1'b0;
  logic [31:0]   e_data [2] = '{default: '0};
  logic [3:0]    e_mask [2] = '{default: 4'hF};
  logic [TW-1:0] e_tag  [2] = '{default: '0};
  logic [1:0]    e_vd   [2] = '{default: '0};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    left   = SETS;
    m_init = 1'b0;
    m_busy = 1'b0;
    e_rv   = 1'b0;
    for (int w = 0; w < 2; w++) begin
      e_data[w] = '0;
      e_mask[w] = 4'hF;
      e_tag[w]  = '0;
      e_vd[w]   = '0;
    end
  endtask

  task automatic model_step();
    int  s;
    logic acc;
    acc  = req_valid && (left == 0);
    e_rv = acc;
    if (acc) begin
      s = int'(req_address[5:2]);
      for (int w = 0; w < 2; w++) begin
        e_data[w] = mdata[w][s];
        e_mask[w] = mknown[w][s];
        e_tag[w]  = mtag[w][s];
        e_vd[w]   = mvd[w][s];
        if (req_wen_data[w]) begin
          for (int b = 0; b < 4; b++) begin
            if (req_strobe[b]) begin
              mdata[w][s][8*b +: 8] = req_data[8*b +: 8];
              mknown[w][s][b] = 1'b1;
            end
          end
        end
        if (req_wen_tag[w]) begin
          mtag[w][s] = req_tag;
          mvd[w][s]  = req_valid_dirty[2*w +: 2];
        end
      end
    end
    if (left > 0) begin
      left--;
      if (left == 0) begin
        for (int w = 0; w < 2; w++)
          for (int k = 0; k < SETS; k++) begin
            mtag[w][k] = '0;
            mvd[w][k]  = '0;
          end
        m_init = 1'b1;
        m_busy = 1'b0;
      end
    end else if (flush_req) begin
      left   = SETS;
      m_busy = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] m;
    chk("req_ready", 64'(req_ready), 64'(left == 0));
    chk("init_done", 64'(init_done), 64'(m_init));
    chk("flush_busy", 64'(flush_busy), 64'(m_busy));
    chk("resp_valid", 64'(resp_valid), 64'(e_rv));
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{e_mask[w][b]}};
      chk($sformatf("resp_tag[%0d]", w),
          64'(resp_tag[w*TW +: TW]), 64'(e_tag[w]));
      chk($sformatf("resp_vd[%0d]", w),
          64'(resp_valid_dirty[2*w +: 2]), 64'(e_vd[w]));
      chk($sformatf("resp_data[%0d]", w),
          64'(resp_data[32*w +: 32] & m), 64'(e_data[w] & m));
    end
  endtask

  task automatic do_req(input logic v, input int set,
                        input logic [1:0] wd, input logic [1:0] wt,
                        input logic [31:0] d, input logic [3:0] sb,
                        input logic [TW-1:0] tg, input logic [3:0] vd,
                        input logic fl);
    req_valid       = v;
    req_address     = 32'(set) << 2;
    req_wen_data    = wd;
    req_wen_tag     = wt;
    req_data        = d;
    req_strobe      = sb;
    req_tag         = tg;
    req_valid_dirty = vd;
    flush_req       = fl;
    @(negedge clk);
    req_valid    = 1'b0;
    flush_req    = 1'b0;
    req_wen_data = '0;
    req_wen_tag  = '0;
  endtask

  task automatic rd(input int set);
    do_req(1'b1, set, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (!req_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < SETS; k++) begin
        mdata[w][k]  = '0;
        mknown[w][k] = '0;
        mtag[w][k]   = '0;
        mvd[w][k]    = '0;
      end

    fork
      forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else model_step();
      end
      forever begin
        @(negedge clk);
        compare_outputs();
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_resp_data", resp_data, 64'(0));

    // Init sweep
    rst = 1'b1;
    count_busy(n);
    chk("init_cycles", 64'(n), 64'(16));
    chk("init_done_set", 64'(init_done), 64'(1));

    rd(5);
    chk("init_vd", 64'(resp_valid_dirty), 64'(0));
    chk("init_tag", 64'(resp_tag), 64'(0));

    // Refill way 1 with victim read
    do_req(1'b1, 5, 2'b10, 2'b10, 32'hDEADBEEF, 4'hF,
           26'h1234, 4'b0100, 1'b0);
    chk("victim_vd", 64'(resp_valid_dirty), 64'(0));
    chk("victim_tag1", 64'(resp_tag[TW +: TW]), 64'(0));
    rd(5);
    chk("refill_data", 64'(resp_data[63:32]), 64'h0DEADBEEF);
    chk("refill_tag", 64'(resp_tag[TW +: TW]), 64'h1234);
    chk("refill_vd", 64'(resp_valid_dirty), 64'b0100);

    // Partial strobe, mark dirty
    do_req(1'b1, 5, 2'b10, 2'b10, 32'h000000AA, 4'b0001,
           26'h1234, 4'b1100, 1'b0);
    chk("partial_old", 64'(resp_data[63:32]), 64'h0DEADBEEF);
    rd(5);
    chk("partial_data", 64'(resp_data[63:32]), 64'h0DEADBEAA);
    chk("partial_vd", 64'(resp_valid_dirty), 64'b1100);

    // Back-to-back reads
    for (int s = 0; s < 4; s++) begin
      rd(s);
      chk($sformatf("b2b_valid[%0d]", s), 64'(resp_valid), 64'(1));
    end
    @(negedge clk);
    chk("b2b_idle", 64'(resp_valid), 64'(0));

    // Flush with a concurrent read, then a held request
    do_req(1'b1, 5, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    chk("flush_resp", 64'(resp_valid), 64'(1));
    chk("flush_resp_vd", 64'(resp_valid_dirty), 64'b1100);
    chk("flush_busy_on", 64'(flush_busy), 64'(1));
    req_valid   = 1'b1;
    req_address = 32'(9) << 2;
    count_busy(n);
    chk("flush_cycles", 64'(n), 64'(16));
    chk("flush_busy_off", 64'(flush_busy), 64'(0));
    @(negedge clk);
    chk("held_req_resp", 64'(resp_valid), 64'(1));
    req_valid = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      rd(s);
      chk($sformatf("flushed_vd[%0d]", s),
          64'(resp_valid_dirty), 64'(0));
      if (s == 5)
        chk("flush_keeps_data", 64'(resp_data[63:32]),
            64'h0DEADBEAA);
    end

    // Reset in the middle of a flush sweep
    do_req(1'b0, 0, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_busy", 64'(flush_busy), 64'(0));
    chk("midrst_init", 64'(init_done), 64'(0));
    chk("midrst_valid", 64'(resp_valid), 64'(0));
    chk("midrst_data", resp_data, 64'(0));
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    chk("reinit_cycles", 64'(n), 64'(16));
    chk("reinit_done", 64'(init_done), 64'(1));
    rd(5);
    chk("reinit_vd", 64'(resp_valid_dirty), 64'(0));
    chk("reinit_data", 64'(resp_data[63:32]), 64'h0DEADBEAA);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_way_array.md
# cache_way_array

Parametrised successor to the per-way tag/valid-dirty/data storage of the cache. Holds `WAYS` ways of `SETS` lines, with the following additions:
- a ready/valid request handshake;
- a response-valid strobe;
- read-old-on-write semantics, so the victim line and the refill are handled in one access;
- a hardware sweep FSM that clears all valid/dirty bits and tags after reset and on a flush command. Synthesised SRAMs are not initialised.

It sits between the cache controller and the tag comparator.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `SETS`, 1024, sets per way (power of 2, ≥2)
- `WAYS`, 2, associativity (≥1)
- `CACHE_LINE_SIZE`, 32, line width in bits (multiple of 8)
- `TAG_WIDTH`, `ADDRESS_WIDTH - clog2(SETS) - clog2(CACHE_LINE_SIZE/8)`, tag bits

Ports:
- `clk` in 1: the single clock
- `rst` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: array accepts a request this cycle
- `req_address` in ADDRESS_WIDTH: set index = `address[offset +: clog2(SETS)]`
- `req_tag` in TAG_WIDTH: tag to write
- `req_data` in CACHE_LINE_SIZE: line data to write
- `req_strobe` in CACHE_LINE_SIZE/8: byte enables for data writes
- `req_wen_data` in WAYS: per-way data write enable
- `req_wen_tag` in WAYS: per-way tag + valid/dirty write enable
- `req_valid_dirty` in WAYS×2: per-way {dirty, valid}, with bit 0 = valid
- `flush_req` in 1: pulse; invalidate every line
- `flush_busy` out 1: flush sweep pending or running
- `init_done` out 1: first post-reset sweep complete
- `resp_valid` out 1: response data valid
- `resp_data` out WAYS×CACHE_LINE_SIZE: per-way line
- `resp_tag` out WAYS×TAG_WIDTH: per-way tag
- `resp_valid_dirty` out WAYS×2: per-way {dirty, valid}

## Operation
- **FSM states:** `INIT`, `READY`, `FLUSH`.
- **Reset (`rst`=0):**
  - State goes to `INIT` and the sweep counter is set to 0.
  - All outputs go to 0: `req_ready`, `resp_valid`, `resp_*`, `init_done`, `flush_busy`.
- **`INIT`:**
  - Each cycle, write tag=0 and valid_dirty=0 to set `cnt` in all ways, then `cnt`++.
  - After set `SETS-1`, go to `READY` and set `init_done`=1; it stays 1 until the next reset.
  - Data arrays are never cleared.
- **`READY`:**
  - `req_ready`=1. A request is accepted when `req_valid & req_ready`.
  - Every way is read at the set index.
  - Ways with `req_wen_data[i]` write the strobed bytes of `req_data`.
  - Ways with `req_wen_tag[i]` write `req_tag` and `req_valid_dirty[i]`.
- **Read-old semantics:** the response for a written way returns the contents before the write. This yields victim data for writeback.
- **`flush_req` in `READY`:**
  - `flush_busy` goes to 1 in the next cycle.
  - The FSM enters `FLUSH`, runs the same sweep as `INIT`, and returns to `READY`.
  - `flush_busy` goes to 0 on the return.
- **Flush outside `READY`:** `flush_req` during `INIT` or `FLUSH` is ignored. The sweep already clears everything.
- **Simultaneous `req_valid` and `flush_req` in `READY`:**
  - The request is accepted and completes normally.
  - The flush starts the next cycle.
- **No queueing:** `req_valid` while `req_ready`=0 is not accepted. The requester holds its request.

## Timing
- **Request to response:**
  - `resp_valid`=1 exactly one cycle after each accepted request, for one cycle.
  - Back-to-back requests give back-to-back responses.
- **Response hold:** `resp_*` hold their last value when `resp_valid`=0.
  - Sweep writes do not update `resp_*`.
- **Sweep length:**
  - `INIT` lasts exactly `SETS` cycles after reset deassertion; `req_ready` rises in cycle `SETS`.
  - A flush costs `SETS`+1 cycles from the `flush_req` edge to `req_ready`=1.
- **Read after write:** a write to set S followed next cycle by a read of S returns the new data.
- **Reset mid-sweep or mid-request:**
  - The sweep restarts at set 0 and `init_done` returns to 0.
  - A pending response is dropped (`resp_valid`=0).
- **Sweep counter:** `clog2(SETS)` bits; terminal at `SETS-1` with no wrap beyond.

## Structure
- **`cache_pkg`:** `ADDRESS_WIDTH`, `SETS`, `WAYS`, `CACHE_LINE_SIZE`, `TAG_WIDTH`, and `OFFSET_BITS` / `SET_BITS` derived constants.
- **`interface_pkg`:** typedefs `way_array_req_t` (request bundle) and `way_array_resp_t`; the enum `way_array_state_e` {`INIT`, `READY`, `FLUSH`}.
- **Sub-module `sram_1rw_be`:** a single-port RAM with 1-cycle read latency, per-byte write enable, and read-old on a same-cycle write.
  - It is instantiated three times per way (valid_dirty, tag, data).
  - Valid_dirty and tag use all-ones byte enables.

## Test plan
All scenarios use `SETS`=16, `WAYS`=2, `CACHE_LINE_SIZE`=32, `ADDRESS_WIDTH`=32.
- **Reset and init:**
  - Stimulus: release reset.
  - Required: `req_ready`=0 for 16 cycles, then 1, with `init_done`=1. A read of set 5 then returns `resp_valid_dirty`=00 and tag 0 in both ways.
- **Refill with victim read:**
  - Stimulus: write way 1, address 0x0000_0054, data 0xDEADBEEF, strobe 4'b1111, tag 0x1234, vd=01.
  - Required: the response shows the old way-1 contents. A next-cycle read shows data 0xDEADBEEF, tag 0x1234, vd=01 in way 1, and way 0 unchanged.
- **Partial strobe:**
  - Stimulus: on that line, write 0x000000AA with strobe 4'b0001 and vd=11.
  - Required: a read returns 0xDEADBEAA with dirty=1.
- **Back-to-back traffic:**
  - Stimulus: 4 consecutive reads of sets 0–3.
  - Required: `resp_valid` high for the 4 cycles that follow, in order.
- **Flush with concurrent request:**
  - Stimulus: `flush_req` and a read in the same cycle.
  - Required: the read responds, `flush_busy`=1, and `req_ready`=0 for 16 cycles. Afterwards every set reads vd=00 and data is preserved.
- **Reset mid-flush:**
  - Stimulus: assert `rst`=0 at sweep count 7.
  - Required: all outputs go to 0 immediately, and after release `INIT` takes a full 16 cycles.
